// File: rtl/aes_sbox_sched_if.sv
// Bundle between the two S-box requesters, the randomness source, the shared
// masked S-box and the result consumers.
interface aes_sbox_sched_if #(
    parameter int SHARES = 2,
    parameter int RND_W  = 36,
    parameter int TAG_W  = 4
);
    logic                  req_a;
    logic [8*SHARES-1:0]   data_a;
    logic [TAG_W-1:0]      tag_a;
    logic                  ack_a;
    logic                  req_b;
    logic [8*SHARES-1:0]   data_b;
    logic [TAG_W-1:0]      tag_b;
    logic                  ack_b;
    logic                  abort;
    logic                  rnd_valid;
    logic [RND_W-1:0]      rnd;
    logic                  rnd_ready;
    logic [8*SHARES-1:0]   sbox_x;
    logic [RND_W-1:0]      sbox_rnd;
    logic [8*SHARES-1:0]   sbox_q;
    logic                  out_valid;
    logic                  out_src;
    logic [TAG_W-1:0]      out_tag;
    logic [8*SHARES-1:0]   out_q;
    logic                  busy;
    logic                  rnd_err;

    modport master (
        output req_a, data_a, tag_a, req_b, data_b, tag_b,
        output abort, rnd_valid, rnd, sbox_q,
        input  ack_a, ack_b, rnd_ready, sbox_x, sbox_rnd,
        input  out_valid, out_src, out_tag, out_q, busy, rnd_err
    );

    modport slave (
        input  req_a, data_a, tag_a, req_b, data_b, tag_b,
        input  abort, rnd_valid, rnd, sbox_q,
        output ack_a, ack_b, rnd_ready, sbox_x, sbox_rnd,
        output out_valid, out_src, out_tag, out_q, busy, rnd_err
    );
endinterface

// File: rtl/aes_sbox_sched.sv
// Round-robin issue controller for a shared fixed-latency masked AES S-box;
// a tag pipeline mirrors the S-box depth and routes each result to its owner.
module aes_sbox_sched #(
    parameter int SHARES  = 2,
    parameter int LATENCY = 4,
    parameter int RND_W   = 36,
    parameter int TAG_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    aes_sbox_sched_if.slave bus
);
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic                 issue;
    logic                 grant_b;
    logic                 prio_b;
    logic                 live;
    logic                 retire;
    logic                 rnd_err_q;
    logic [CNT_W-1:0]     in_flight;
    logic [LATENCY-1:0]   vld_pipe;
    logic [LATENCY-1:0]   src_pipe;
    logic [TAG_W-1:0]     tag_pipe [LATENCY];

    always_comb begin
        live    = (in_flight != '0);
        issue   = (bus.req_a | bus.req_b) & bus.rnd_valid & ~bus.abort & ~rst;
        grant_b = bus.req_b & (~bus.req_a | prio_b);
        retire  = vld_pipe[LATENCY-1];
    end

    assign bus.ack_a     = issue & ~grant_b;
    assign bus.ack_b     = issue & grant_b;
    // Zero the S-box input when idle so no stale shares linger on it.
    assign bus.sbox_x    = issue ? (grant_b ? bus.data_b : bus.data_a) : '0;
    assign bus.rnd_ready = bus.rnd_valid & (issue | live) & ~rst;
    assign bus.sbox_rnd  = bus.rnd_ready ? bus.rnd : '0;

    assign bus.out_valid = vld_pipe[LATENCY-1] & ~rst;
    assign bus.out_src   = bus.out_valid & src_pipe[LATENCY-1];
    assign bus.out_tag   = bus.out_valid ? tag_pipe[LATENCY-1] : '0;
    assign bus.out_q     = bus.out_valid ? bus.sbox_q : '0;
    assign bus.busy      = live & ~rst;
    assign bus.rnd_err   = rnd_err_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            in_flight <= '0;
            rnd_err_q <= 1'b0;
            prio_b    <= 1'b1;
        end else begin
            // The S-box cannot stall, so an underflow is only flagged.
            if (live && !bus.rnd_valid) begin
                rnd_err_q <= 1'b1;
            end
            if (bus.abort) begin
                vld_pipe  <= '0;
                in_flight <= '0;
            end else begin
                for (int i = LATENCY - 1; i > 0; i--) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                end
                vld_pipe[0] <= issue;
                in_flight   <= in_flight + CNT_W'(issue) - CNT_W'(retire);
            end
            if (issue) begin
                prio_b <= ~grant_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) begin
            src_pipe[i] <= src_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
        end
        src_pipe[0] <= grant_b;
        tag_pipe[0] <= grant_b ? bus.tag_b : bus.tag_a;
    end
endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: behavioural S-box environment plus a queue-based
// reference model of issue, ownership, timing and randomness accounting.
module tb_aes_sbox_sched;
    localparam int SHARES  = 2;
    localparam int LATENCY = 4;
    localparam int RND_W   = 36;
    localparam int TAG_W   = 4;
    localparam int DW      = 8 * SHARES;

    typedef struct {
        int               due;
        logic             src;
        logic [TAG_W-1:0] tag;
        logic [7:0]       val;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    res_t exp_q[$];
    logic m_prio_b = 1'b1;
    logic m_err    = 1'b0;
    logic got_a, got_b;

    always #5 clk = ~clk;

    aes_sbox_sched_if #(.SHARES(SHARES), .RND_W(RND_W), .TAG_W(TAG_W)) bus();

    aes_sbox_sched #(.SHARES(SHARES), .LATENCY(LATENCY), .RND_W(RND_W), .TAG_W(TAG_W))
        dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [7:0] gmul(logic [7:0] a_in, logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // AES S-box from its definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox_fn(logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int i = 1; i < 256; i++) begin
            if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] recomb(logic [DW-1:0] v);
        logic [7:0] r = 8'h00;
        for (int s = 0; s < SHARES; s++) r = r ^ v[8*s +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] share(logic [7:0] x);
        logic [7:0] m = 8'($urandom);
        return {m, x ^ m};
    endfunction

    function automatic logic [RND_W-1:0] rnd_word();
        return RND_W'({$urandom, $urandom});
    endfunction

    // Shared S-box stand-in: fixed latency, output re-masked with a fresh mask.
    logic [7:0] env_val [LATENCY];
    logic [7:0] env_msk [LATENCY];
    always @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) begin
            env_val[i] <= env_val[i-1];
            env_msk[i] <= env_msk[i-1];
        end
        env_val[0] <= sbox_fn(recomb(bus.sbox_x));
        env_msk[0] <= 8'($urandom);
    end
    assign bus.sbox_q = {env_msk[LATENCY-1], env_val[LATENCY-1] ^ env_msk[LATENCY-1]};

    task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
        end
    endtask

    // Compare one cycle of DUT outputs with the model, then advance the model.
    task automatic step();
        logic e_issue, e_gb, e_ready, e_ov;
        logic [DW-1:0] e_x;
        res_t r;
        @(negedge clk);
        e_issue = (bus.req_a | bus.req_b) & bus.rnd_valid & ~bus.abort & ~rst;
        e_gb    = bus.req_b & (~bus.req_a | m_prio_b);
        check("ack_a", 64'(bus.ack_a), 64'(e_issue & ~e_gb));
        check("ack_b", 64'(bus.ack_b), 64'(e_issue & e_gb));
        e_x = e_issue ? (e_gb ? bus.data_b : bus.data_a) : '0;
        check("sbox_x", 64'(bus.sbox_x), 64'(e_x));
        e_ready = bus.rnd_valid & (e_issue | (exp_q.size() != 0)) & ~rst;
        check("rnd_ready", 64'(bus.rnd_ready), 64'(e_ready));
        check("sbox_rnd", 64'(bus.sbox_rnd), e_ready ? 64'(bus.rnd) : 64'h0);
        e_ov = !rst && exp_q.size() != 0 && exp_q[0].due == cyc;
        check("out_valid", 64'(bus.out_valid), 64'(e_ov));
        if (e_ov) begin
            check("out_src", 64'(bus.out_src), 64'(exp_q[0].src));
            check("out_tag", 64'(bus.out_tag), 64'(exp_q[0].tag));
            check("out_q_recomb", 64'(recomb(bus.out_q)), 64'(exp_q[0].val));
        end else begin
            check("out_q_idle", 64'(bus.out_q), 64'h0);
        end
        check("busy", 64'(bus.busy), 64'(!rst && exp_q.size() != 0));
        check("rnd_err", 64'(bus.rnd_err), 64'(m_err & ~rst));
        got_a = e_issue & ~e_gb;
        got_b = e_issue & e_gb;
        if (rst) begin
            exp_q.delete();
            m_prio_b = 1'b1;
            m_err    = 1'b0;
        end else begin
            if (exp_q.size() != 0 && !bus.rnd_valid) m_err = 1'b1;
            if (bus.abort) exp_q.delete();
            else if (e_ov) void'(exp_q.pop_front());
            if (e_issue) begin
                r.due = cyc + LATENCY;
                r.src = e_gb;
                r.tag = e_gb ? bus.tag_b : bus.tag_a;
                r.val = sbox_fn(recomb(e_gb ? bus.data_b : bus.data_a));
                exp_q.push_back(r);
                m_prio_b = ~e_gb;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        for (int i = 0; i <= LATENCY; i++) step();
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_a     = 1'b0;
        bus.data_a    = '0;
        bus.tag_a     = '0;
        bus.req_b     = 1'b0;
        bus.data_b    = '0;
        bus.tag_b     = '0;
        bus.abort     = 1'b0;
        bus.rnd_valid = 1'b0;
        bus.rnd       = '0;
        step();
        step();
        rst = 1'b0;
        bus.rnd_valid = 1'b1;
        bus.rnd       = rnd_word();
        step();

        // Single A request of the all-zero byte.
        bus.req_a  = 1'b1;
        bus.data_a = '0;
        bus.tag_a  = 4'd3;
        step();
        drain();

        // Both requesters continuously: alternating grants, no bubbles.
        bus.req_a  = 1'b1;
        bus.data_a = share(8'h53);
        bus.tag_a  = 4'd5;
        bus.req_b  = 1'b1;
        bus.data_b = share(8'h01);
        bus.tag_b  = 4'd9;
        for (int i = 0; i < 8; i++) begin
            bus.rnd = rnd_word();
            step();
            if (got_a) begin bus.data_a = share(8'h53); bus.tag_a = bus.tag_a + 4'd1; end
            if (got_b) begin bus.data_b = share(8'h01); bus.tag_b = bus.tag_b + 4'd1; end
        end
        drain();

        // Waiting on randomness while idle.
        bus.req_a     = 1'b1;
        bus.data_a    = share(8'hc3);
        bus.tag_a     = 4'd7;
        bus.rnd_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.rnd_valid = 1'b1;
        step();
        drain();

        // Randomness underflow during the in-flight window.
        bus.req_a  = 1'b1;
        bus.data_a = share(8'h2a);
        bus.tag_a  = 4'd1;
        step();
        bus.req_a     = 1'b0;
        bus.rnd_valid = 1'b0;
        step();
        step();
        bus.rnd_valid = 1'b1;
        drain();
        step();

        // Abort with three bytes in flight and a request held through it.
        bus.req_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_a = share(8'(i * 37 + 5));
            bus.tag_a  = 4'(i + 10);
            step();
        end
        bus.data_a = share(8'h99);
        bus.tag_a  = 4'd14;
        bus.abort  = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        drain();

        // Reset with two bytes in flight, then both requesting.
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_a = share(8'h10);
        bus.data_b = share(8'h20);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        drain();

        // Randomised traffic with request holding until acknowledge.
        got_a = 1'b1;
        got_b = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!bus.req_a || got_a) begin
                bus.req_a  = ($urandom_range(0, 3) != 0);
                bus.data_a = share(8'($urandom));
                bus.tag_a  = 4'($urandom);
            end
            if (!bus.req_b || got_b) begin
                bus.req_b  = ($urandom_range(0, 3) != 0);
                bus.data_b = share(8'($urandom));
                bus.tag_b  = 4'($urandom);
            end
            bus.rnd_valid = ($urandom_range(0, 9) != 0);
            bus.abort     = ($urandom_range(0, 29) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            bus.rnd       = rnd_word();
            step();
        end
        rst           = 1'b0;
        bus.abort     = 1'b0;
        bus.rnd_valid = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_sbox_sched.md
Name: aes_sbox_sched

Overview:
- Issue controller and arbiter for the shared masked pipelined AES S-box (DOM, SHARES-share, fixed latency, no stall input).
- Two requesters share one S-box:
  - Requester A is the SubBytes state path.
  - Requester B is the key-schedule SubWord path.
- Gates issue on availability of fresh randomness and forwards that randomness to the S-box.
- Tracks in-flight bytes with a tag pipeline and returns each result to its owner with the owner's tag.

Parameters:
- SHARES, 2, number of Boolean shares per byte.
- LATENCY, 4, S-box latency in cycles from input to output; must be 1..8.
- RND_W, 36, width of fresh randomness consumed per S-box cycle (RandomZ plus RandomB width).
- TAG_W, 4, requester tag width.

Ports:
- ClkxCI, in, 1, clock; rising edge.
- RstxRI, in, 1, reset; synchronous, active-high.
- ReqAxSI, in, 1, requester A request.
- DataAxDI, in, 8*SHARES, requester A shared byte.
- TagAxDI, in, TAG_W, requester A tag.
- AckAxSO, out, 1, requester A accepted this cycle.
- ReqBxSI, in, 1, requester B request.
- DataBxDI, in, 8*SHARES, requester B shared byte.
- TagBxDI, in, TAG_W, requester B tag.
- AckBxSO, out, 1, requester B accepted this cycle.
- AbortxSI, in, 1, squash all in-flight results.
- RndValidxSI, in, 1, fresh randomness available.
- RndxDI, in, RND_W, fresh randomness.
- RndReadyxSO, out, 1, randomness consumed this cycle.
- SboxXxDO, out, 8*SHARES, S-box shared input.
- SboxRndxDO, out, RND_W, S-box randomness.
- SboxQxDI, in, 8*SHARES, S-box shared output.
- OutValidxSO, out, 1, result valid.
- OutSrcxSO, out, 1, result owner; 0 = A, 1 = B.
- OutTagxDO, out, TAG_W, result tag.
- OutQxDO, out, 8*SHARES, result shares.
- BusyxSO, out, 1, in-flight count is nonzero.
- RndErrxSO, out, 1, sticky randomness underflow flag.

Behaviour:
Reset:
- Synchronous, on RstxRI high at a clock edge.
- Clears the valid pipeline, the in-flight count (InFlight) and RndErrxSO.
- Sets the round-robin pointer to favour B.
- All outputs are 0 during and after reset until the next issue; SboxRndxDO is also 0.

Issue:
- issue = (ReqAxSI | ReqBxSI) & RndValidxSI & ~AbortxSI.
- Arbitration is round-robin:
  - If only one requester asks, it is granted.
  - If both ask, the one not granted last is granted.
  - The pointer updates only on issue.
- AckxSO is combinational and asserted only in the issue cycle, for the granted requester only.
- Requesters hold Req, Data and Tag stable until Ack.

S-box input:
- SboxXxDO = granted Data when issue, else all zero. No stale shares are left on the S-box input.

Randomness:
- RndReadyxSO = RndValidxSI & (issue | InFlight != 0). Randomness is consumed every cycle the S-box has a live stage.
- SboxRndxDO = RndxDI when RndReadyxSO, else 0.
- If InFlight != 0 and RndValidxSI = 0:
  - RndErrxSO is set and stays set until reset.
  - The pipeline still advances; the S-box cannot stall.

Tag pipeline:
- Depth LATENCY; each entry holds {valid, src, tag}.
- Stage 0 loads {issue, grant, granted tag}.
- Every entry shifts each cycle unconditionally.
- OutValidxSO, OutSrcxSO and OutTagxDO come from the last stage, so a result appears exactly LATENCY cycles after its Ack cycle.
- OutQxDO = SboxQxDI when OutValidxSO, else 0.

InFlight counter:
- Range 0..LATENCY.
- +1 on issue, -1 when a valid entry leaves the last stage.
- Simultaneous issue and retire leaves the count unchanged.
- It never exceeds LATENCY, because at most one issue happens per cycle.
- BusyxSO = (InFlight != 0).

Abort:
- In the AbortxSI cycle:
  - All valid bits clear and InFlight goes to 0.
  - No Ack is given.
  - OutValidxSO is suppressed from the next cycle on.
- A request held through the abort is re-arbitrated on the first cycle after AbortxSI falls.

Throughput:
- One byte per cycle with back-to-back issue and no bubbles.
- With both requesters active, A and B alternate.

Mid-operation reset: takes priority over Abort and issue; in-flight results are lost.

Test Plan:
1. SHARES=2, only A requests with DataA=(0x00,0x00), tag 3, RndValid=1 -> AckA in cycle 0; cycle LATENCY gives OutValid=1, Src=0, Tag=3, shares XOR to 0x63.
2. A and B request continuously for 8 cycles with DataA=0x53 and DataB=0x01 (masked shares) -> acks in order B,A,B,A…; outputs alternate with Src 1,0,… and recombine to 0x7C (B) and 0xED (A); InFlight stays at LATENCY.
3. A requests while RndValid=0 for 3 cycles, then RndValid=1 -> no Ack and SboxXxDO=0 during the wait, RndErr stays 0; Ack on the 4th cycle.
4. Issue one byte, then drop RndValid during the in-flight window -> RndErr=1 and sticky; the result still appears at LATENCY.
5. Issue 3 bytes, assert Abort in the next cycle -> no OutValid ever appears for them; Busy=0 the cycle after Abort; a new request is acked the cycle after Abort falls.
6. Assert reset with 2 bytes in flight -> all outputs 0 next cycle and no results appear; after reset with both requesting, B is granted first.
